// File: rtl/dma_read_ctrl.sv
// Single-channel DMA read sequencer: accepts a start-address/length command,
// runs a fixed setup phase, then strobes one read beat per cycle and pulses IRQ.
module dma_read_ctrl #(
    parameter int DATA_BYTES   = 4,
    parameter int SETUP_CYCLES = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        dma_read_valid,
    input  logic [25:0] dma_length_config,
    input  logic [31:0] dma_sa_config,
    output logic        DMA_IRQ,
    output logic        dma_idle,
    output logic [31:0] dma_rd_addr,
    output logic        dma_rd_beat,
    output logic        dma_rd_last
);
    localparam int SHIFT = $clog2(DATA_BYTES);
    localparam int CW    = $clog2(SETUP_CYCLES + 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
    localparam logic [31:0]   STRIDE     = 32'(DATA_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        XFER,
        DONE
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [31:0]   sa_q;
    logic [31:0]   sa_n;
    logic [25:0]   rem_q;
    logic [25:0]   rem_n;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_n;
    logic [31:0]   addr_n;
    logic          beat_n;
    logic          last_n;
    logic          irq_n;
    logic          idle_n;
    logic [26:0]   len_round;
    logic [25:0]   cmd_beats;

    // ceil(length / DATA_BYTES); the extra bit absorbs the rounding carry
    assign len_round = {1'b0, dma_length_config} + 27'(DATA_BYTES - 1);
    assign cmd_beats = 26'(len_round >> SHIFT);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            sa_q        <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            dma_rd_addr <= '0;
            dma_rd_beat <= 1'b0;
            dma_rd_last <= 1'b0;
            DMA_IRQ     <= 1'b0;
            dma_idle    <= 1'b1;
        end else begin
            state       <= state_n;
            sa_q        <= sa_n;
            rem_q       <= rem_n;
            cnt_q       <= cnt_n;
            dma_rd_addr <= addr_n;
            dma_rd_beat <= beat_n;
            dma_rd_last <= last_n;
            DMA_IRQ     <= irq_n;
            dma_idle    <= idle_n;
        end
    end

    // rem_q holds the number of beats still to be issued after the current one
    always_comb begin
        state_n = state;
        sa_n    = sa_q;
        rem_n   = rem_q;
        cnt_n   = cnt_q;
        addr_n  = dma_rd_addr;
        beat_n  = 1'b0;
        last_n  = 1'b0;
        irq_n   = 1'b0;
        idle_n  = dma_idle;
        unique case (state)
            IDLE: begin
                if (dma_read_valid) begin
                    state_n = SETUP;
                    sa_n    = dma_sa_config;
                    rem_n   = cmd_beats;
                    cnt_n   = '0;
                    idle_n  = 1'b0;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_n = '0;
                    if (rem_q == '0) begin
                        state_n = DONE;
                        irq_n   = 1'b1;
                    end else begin
                        state_n = XFER;
                        beat_n  = 1'b1;
                        addr_n  = sa_q;
                        last_n  = (rem_q == 26'd1);
                        rem_n   = rem_q - 26'd1;
                    end
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            XFER: begin
                if (rem_q == '0) begin
                    state_n = DONE;
                    irq_n   = 1'b1;
                end else begin
                    beat_n = 1'b1;
                    addr_n = dma_rd_addr + STRIDE;
                    last_n = (rem_q == 26'd1);
                    rem_n  = rem_q - 26'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
                idle_n  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dma_read_ctrl.sv
// Randomized bench for dma_read_ctrl against a time-indexed transfer model.
// Each accepted command predicts idle/beat/addr/last/IRQ for every later cycle.
module tb_dma_read_ctrl;
    localparam int DB = 4;
    localparam int S  = 3;

    logic        CLK;
    logic        RST;
    logic        dma_read_valid;
    logic [25:0] dma_length_config;
    logic [31:0] dma_sa_config;
    logic        DMA_IRQ;
    logic        dma_idle;
    logic [31:0] dma_rd_addr;
    logic        dma_rd_beat;
    logic        dma_rd_last;

    dma_read_ctrl #(
        .DATA_BYTES  (DB),
        .SETUP_CYCLES(S)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .dma_read_valid   (dma_read_valid),
        .dma_length_config(dma_length_config),
        .dma_sa_config    (dma_sa_config),
        .DMA_IRQ          (DMA_IRQ),
        .dma_idle         (dma_idle),
        .dma_rd_addr      (dma_rd_addr),
        .dma_rd_beat      (dma_rd_beat),
        .dma_rd_last      (dma_rd_last)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // model: a transfer accepted at edge t is busy for cycles t..t+S+beats,
    // beats at t+S+k, IRQ at t+S+beats
    int          cyc      = 0;
    bit          m_busy   = 0;
    int          t_acc    = 0;
    int          m_beats  = 0;
    logic [31:0] m_sa     = '0;
    int          accepts  = 0;
    int          aborted  = 0;
    int          irq_seen = 0;
    int          run      = 0;
    int          m_run    = 0;

    always @(posedge CLK) begin
        cyc++;
        if (!RST) begin
            if (m_busy && cyc - 1 < t_acc + S + m_beats) aborted++;
            m_busy = 0;
        end else if ((!m_busy || cyc - 1 >= t_acc + S + m_beats + 1)
                     && dma_read_valid === 1'b1) begin
            m_busy  = 1;
            t_acc   = cyc;
            m_sa    = dma_sa_config;
            m_beats = (int'(dma_length_config) + DB - 1) / DB;
            m_run   = S + m_beats + 1;
            accepts++;
        end
    end

    always @(negedge CLK) begin
        bit busy;
        bit e_beat;
        bit e_irq;
        int k;
        busy   = m_busy && (cyc < t_acc + S + m_beats + 1);
        k      = cyc - t_acc - S;
        e_beat = busy && k >= 0 && k < m_beats;
        e_irq  = busy && (cyc == t_acc + S + m_beats);
        chk("idle", {31'd0, dma_idle}, {31'd0, !busy});
        chk("beat", {31'd0, dma_rd_beat}, {31'd0, e_beat});
        chk("irq", {31'd0, DMA_IRQ}, {31'd0, e_irq});
        chk("last", {31'd0, dma_rd_last},
            {31'd0, e_beat && (k == m_beats - 1)});
        if (e_beat) chk("addr", dma_rd_addr, m_sa + 32'(k) * 32'(DB));
        if (DMA_IRQ === 1'b1) irq_seen++;
        if (!RST) begin
            run = 0;
        end else if (dma_idle !== 1'b1) begin
            run++;
        end else if (run > 0) begin
            chk("idle_run", run, m_run);
            run = 0;
        end
    end

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (dma_idle !== 1'b1 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        chk(tag, {31'd0, n < 2000}, 32'd1);
    endtask

    task automatic run_cmd(input logic [31:0] sa, input logic [25:0] len);
        wait_idle("cmd_wait");
        dma_read_valid    = 1'b1;
        dma_sa_config     = sa;
        dma_length_config = len;
        @(negedge CLK);
        dma_read_valid = 1'b0;
        dma_sa_config  = 'x;
        @(negedge CLK);
        wait_idle("cmd_done");
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        logic [31:0] sa;
        bit          pv;
        int          n;
        RST               = 1'b0;
        dma_read_valid    = 1'b0;
        dma_length_config = '0;
        dma_sa_config     = '0;
        repeat (2) @(negedge CLK);
        chk("rst_addr", dma_rd_addr, 32'd0);
        RST           = 1'b1;
        dma_sa_config = 'x;
        repeat (5) @(negedge CLK);

        // basic: requester re-issues whenever it sees idle
        dma_sa_config     = 32'h0;
        dma_length_config = 26'h40;
        repeat (60) begin
            dma_read_valid = dma_idle;
            @(negedge CLK);
        end
        dma_read_valid = 1'b0;
        wait_idle("basic_end");

        // incrementing stream
        sa = 32'h0;
        pv = 1'b0;
        n  = 0;
        while (sa <= 32'h800 && n < 5000) begin
            dma_sa_config     = sa;
            dma_length_config = 26'h40;
            dma_read_valid    = dma_idle;
            if (pv && !dma_read_valid) sa = sa + 32'h20;
            pv = dma_read_valid;
            @(negedge CLK);
            n++;
        end
        chk("stream_bound", {31'd0, n < 5000}, 32'd1);
        dma_read_valid = 1'b0;
        wait_idle("stream_end");

        run_cmd(32'h0000_0100, 26'h41);
        run_cmd(32'h0000_0200, 26'h0);
        run_cmd(32'hFFFF_FFF8, 26'h10);
        run_cmd(32'h0000_0013, 26'h1);
        run_cmd(32'h0000_0400, 26'h3);

        // busy: valid held high, config scrambled every cycle
        wait_idle("busy_wait");
        dma_read_valid    = 1'b1;
        dma_sa_config     = 32'h300;
        dma_length_config = 26'h20;
        @(negedge CLK);
        repeat (40) begin
            dma_sa_config     = $urandom;
            dma_length_config = 26'($urandom_range(0, 64));
            @(negedge CLK);
        end
        dma_read_valid = 1'b0;
        wait_idle("busy_end");

        // random traffic, X on SA while idle and not requesting
        repeat (1500) begin
            dma_read_valid    = ($urandom_range(0, 3) == 0);
            dma_length_config = ($urandom_range(0, 7) == 0)
                              ? 26'd0 : 26'($urandom_range(1, 200));
            if (dma_read_valid || dma_idle !== 1'b1)
                dma_sa_config = $urandom;
            else
                dma_sa_config = 'x;
            @(negedge CLK);
        end
        dma_read_valid = 1'b0;
        wait_idle("rand_end");

        // reset abort mid-XFER
        dma_read_valid    = 1'b1;
        dma_sa_config     = 32'h1000;
        dma_length_config = 26'h100;
        @(negedge CLK);
        dma_read_valid = 1'b0;
        n = 0;
        while (dma_rd_beat !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("abort_beat_seen", {31'd0, n < 50}, 32'd1);
        repeat (3) @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        chk("abort_beat", {31'd0, dma_rd_beat}, 32'd0);
        chk("abort_idle", {31'd0, dma_idle}, 32'd1);
        chk("abort_irq", {31'd0, DMA_IRQ}, 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        repeat (10) @(negedge CLK);
        run_cmd(32'h0000_2000, 26'h8);

        chk("irq_count", irq_seen, accepts - aborted);
        chk("abort_count", aborted, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
